// File: rtl/execute_if.sv
// Qu core execute-stage types and the issue/retire bus bundle.
// qu_pkg holds the issued-op cell layout shared by reservation stations,
// execute and retire. execute_if groups the op handshake and result signals:
// master = issue/retire side, slave = execute stage.
package qu_pkg;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    UOP_NOP, UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_SLL, UOP_SRL,
    UOP_SRA, UOP_SLT, UOP_SLTU, UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU,
    UOP_BGEU, UOP_JALR, UOP_LOAD, UOP_STORE, UOP_MUL, UOP_MULH, UOP_MULHSU,
    UOP_MULHU, UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU
  } uop_t;

  typedef struct packed {
    logic            busy;
    uop_t            op;
    logic [XLEN-1:0] vj;
    logic [XLEN-1:0] vk;
    logic [XLEN-1:0] a;
    logic [5:0]      dest;
    logic [4:0]      rob_addr;
  } res_st_cell_t;
endpackage

interface execute_if;
  import qu_pkg::*;
  res_st_cell_t    op_in;
  logic            exec_ready;
  logic [XLEN-1:0] value_out;
  logic            comp_result_out;
  res_st_cell_t    op_out;

  modport master (output op_in, input exec_ready, value_out, comp_result_out, op_out);
  modport slave  (input op_in, output exec_ready, value_out, comp_result_out, op_out);
endinterface

// File: rtl/execute.sv
// Qu core execution stage. One issued op is captured per accept edge and its
// result is registered one edge later (ALU/branch/addr/jump), MUL_STAGES edges
// later (multiplies) or 33 edges later (divides). Issue is held off through
// exec_ready while a multi-cycle op occupies the stage.
// Build option: define QU_EXEC_DIV_EN to build the 32-step restoring divider
// and its DIV state; without it, div/rem uops finish in one cycle with all-ones.
module execute import qu_pkg::*; #(
  parameter int MUL_STAGES = 2
) (
  input logic       i_clk,
  input logic       i_rst,
  input logic       i_flush,
  execute_if.slave  bus
);

  // state | meaning
  // IDLE  | ready for a new op; completes whatever sits in the capture register
  // MUL   | multiply captured, waiting out the remaining multiply cycles
  // DIV   | divider iterating, one quotient bit per cycle
`ifdef QU_EXEC_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  localparam int CW = 6;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  res_st_cell_t    r_op;
  logic            r_valid;
  logic [XLEN-1:0] r_value;
  logic            r_comp;
  res_st_cell_t    r_op_out;

  logic [XLEN-1:0]   w_vj, w_vk, w_a;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0]   w_res_val;
  logic              w_res_comp;
  logic              w_in_mul;

  assign w_vj = r_op.vj;
  assign w_vk = r_op.vk;
  assign w_a  = r_op.a;

  // Low 64 bits of the two's-complement product are correct for every signedness mix.
  assign w_ma   = {{XLEN{(r_op.op == UOP_MULH || r_op.op == UOP_MULHSU) & w_vj[XLEN-1]}}, w_vj};
  assign w_mb   = {{XLEN{(r_op.op == UOP_MULH) & w_vk[XLEN-1]}}, w_vk};
  assign w_prod = w_ma * w_mb;

  assign w_in_mul = bus.op_in.op inside {UOP_MUL, UOP_MULH, UOP_MULHSU, UOP_MULHU};

`ifdef QU_EXEC_DIV_EN
  logic [XLEN-1:0] r_quo, r_rem, r_dvs;
  logic            r_neg_q, r_neg_r, r_div0;
  logic            w_in_div, w_in_signed, w_in_sa, w_in_sb;
  logic [XLEN-1:0] w_in_mag_a, w_in_mag_b;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff, w_q_fix, w_r_fix;

  assign w_in_div    = bus.op_in.op inside {UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU};
  assign w_in_signed = bus.op_in.op inside {UOP_DIV, UOP_REM};
  assign w_in_sa     = w_in_signed & bus.op_in.vj[XLEN-1];
  assign w_in_sb     = w_in_signed & bus.op_in.vk[XLEN-1];
  assign w_in_mag_a  = w_in_sa ? -bus.op_in.vj : bus.op_in.vj;
  assign w_in_mag_b  = w_in_sb ? -bus.op_in.vk : bus.op_in.vk;

  // Remainder stays below the divisor, so the 32-bit difference is exact when w_ge.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

  // Divide-by-zero already leaves the remainder equal to the dividend; only the quotient is forced.
  assign w_q_fix = r_div0 ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;
`endif

  // Result of the captured op, consumed on the edge it completes.
  always_comb begin
    w_res_val  = '0;
    w_res_comp = 1'b0;
    case (r_op.op)
      UOP_ADD:    w_res_val = w_vj + w_vk;
      UOP_SUB:    w_res_val = w_vj - w_vk;
      UOP_AND:    w_res_val = w_vj & w_vk;
      UOP_OR:     w_res_val = w_vj | w_vk;
      UOP_XOR:    w_res_val = w_vj ^ w_vk;
      UOP_SLL:    w_res_val = w_vj << w_vk[4:0];
      UOP_SRL:    w_res_val = w_vj >> w_vk[4:0];
      UOP_SRA:    w_res_val = $signed(w_vj) >>> w_vk[4:0];
      UOP_SLT:    w_res_val = {{(XLEN-1){1'b0}}, $signed(w_vj) < $signed(w_vk)};
      UOP_SLTU:   w_res_val = {{(XLEN-1){1'b0}}, w_vj < w_vk};
      UOP_BEQ:  begin w_res_val = w_a; w_res_comp = (w_vj == w_vk); end
      UOP_BNE:  begin w_res_val = w_a; w_res_comp = (w_vj != w_vk); end
      UOP_BLT:  begin w_res_val = w_a; w_res_comp = ($signed(w_vj) <  $signed(w_vk)); end
      UOP_BGE:  begin w_res_val = w_a; w_res_comp = ($signed(w_vj) >= $signed(w_vk)); end
      UOP_BLTU: begin w_res_val = w_a; w_res_comp = (w_vj <  w_vk); end
      UOP_BGEU: begin w_res_val = w_a; w_res_comp = (w_vj >= w_vk); end
      UOP_JALR: begin w_res_val = (w_vj + w_a) & ~XLEN'(1); w_res_comp = 1'b1; end
      UOP_LOAD, UOP_STORE: w_res_val = w_vj + w_a;
      UOP_MUL:    w_res_val = w_prod[XLEN-1:0];
      UOP_MULH, UOP_MULHSU, UOP_MULHU: w_res_val = w_prod[2*XLEN-1:XLEN];
`ifdef QU_EXEC_DIV_EN
      UOP_DIV, UOP_DIVU: w_res_val = w_q_fix;
      UOP_REM, UOP_REMU: w_res_val = w_r_fix;
`else
      UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU: w_res_val = '1;
`endif
      default:    w_res_val = '0;
    endcase
  end

  // Stage FSM: capture, multi-cycle sequencing, divider steps and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_valid  <= 1'b0;
      r_value  <= '0;
      r_comp   <= 1'b0;
      r_op_out <= '0;
`ifdef QU_EXEC_DIV_EN
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`endif
    end else begin
      r_value  <= '0;
      r_comp   <= 1'b0;
      r_op_out <= '0;
      if (i_flush) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_valid) begin
              r_value  <= w_res_val;
              r_comp   <= w_res_comp;
              r_op_out <= r_op;
            end
            r_valid <= bus.op_in.busy;
            r_op    <= bus.op_in;
            if (bus.op_in.busy) begin
              if (w_in_mul && MUL_STAGES > 1) begin
                r_state <= S_MUL;
                r_cnt   <= CW'(MUL_STAGES - 2);
              end
`ifdef QU_EXEC_DIV_EN
              else if (w_in_div) begin
                r_state <= S_DIV;
                r_cnt   <= CW'(XLEN - 1);
                r_quo   <= w_in_mag_a;
                r_rem   <= '0;
                r_dvs   <= w_in_mag_b;
                r_neg_q <= w_in_sa ^ w_in_sb;
                r_neg_r <= w_in_sa;
                r_div0  <= (bus.op_in.vk == '0);
              end
`endif
            end
          end
          S_MUL: begin
            if (r_cnt == '0) r_state <= S_IDLE;
            else             r_cnt   <= r_cnt - CW'(1);
          end
`ifdef QU_EXEC_DIV_EN
          S_DIV: begin
            r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            if (r_cnt == '0) r_state <= S_IDLE;
            else             r_cnt   <= r_cnt - CW'(1);
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.exec_ready      = (r_state == S_IDLE);
  assign bus.value_out       = r_value;
  assign bus.comp_result_out = r_comp;
  assign bus.op_out          = r_op_out;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the Qu execute stage: hand-computed results, latencies,
// stall behaviour, flush and reset. Divider vectors follow QU_EXEC_DIV_EN.
module tb_execute;
  import qu_pkg::*;

  logic clk, rst, flush;
  int   n_checks, n_fails;

  execute_if bus ();

  execute #(.MUL_STAGES(2)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_st_cell_t mk(input uop_t op, input logic [31:0] vj, input logic [31:0] vk,
                                      input logic [31:0] a, input logic [5:0] dest, input logic [4:0] rob);
    res_st_cell_t c;
    c.busy = 1'b1; c.op = op; c.vj = vj; c.vk = vk; c.a = a; c.dest = dest; c.rob_addr = rob;
    return c;
  endfunction

  // Issue one op from idle and check its latency, value, condition and echoed op.
  task automatic run_op(input string tag, input res_st_cell_t op, input int lat,
                        input logic [31:0] ev, input logic ec);
    int cyc;
    bus.op_in = op;
    step();
    bus.op_in = '0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      step();
      if (bus.op_out.busy) break;
    end
    chk({tag, "_lat"}, 128'(cyc), 128'(lat));
    chk({tag, "_val"}, 128'(bus.value_out), 128'(ev));
    chk({tag, "_cmp"}, 128'(bus.comp_result_out), 128'(ec));
    chk({tag, "_op"}, 128'(bus.op_out), 128'(op));
  endtask

  initial begin
    bit seen;
    n_checks = 0;
    n_fails  = 0;
    bus.op_in = '0;
    flush = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_ready", 128'(bus.exec_ready), 128'(1));
    chk("rst_val",   128'(bus.value_out), 128'(0));
    chk("rst_cmp",   128'(bus.comp_result_out), 128'(0));
    chk("rst_op",    128'(bus.op_out), 128'(0));

    // single ADD: result one edge after accept, then a bubble
    bus.op_in = mk(UOP_ADD, 5, 10, 0, 6'd3, 5'd1);
    step();
    bus.op_in = '0;
    chk("add_ready", 128'(bus.exec_ready), 128'(1));
    step();
    chk("add_val",  128'(bus.value_out), 128'(15));
    chk("add_busy", 128'(bus.op_out.busy), 128'(1));
    chk("add_dest", 128'(bus.op_out.dest), 128'(3));
    chk("add_rob",  128'(bus.op_out.rob_addr), 128'(1));
    step();
    chk("add_bub_busy", 128'(bus.op_out.busy), 128'(0));
    chk("add_bub_val",  128'(bus.value_out), 128'(0));

    // back-to-back ADD then BLT
    bus.op_in = mk(UOP_ADD, 8, 7, 0, 6'd4, 5'd2);
    step();
    bus.op_in = mk(UOP_BLT, 32'hFFFF_FFFF, 1, 32'h40, 6'd0, 5'd3);
    chk("b2b_ready", 128'(bus.exec_ready), 128'(1));
    step();
    bus.op_in = '0;
    chk("b2b_val1", 128'(bus.value_out), 128'(15));
    step();
    chk("b2b_val2", 128'(bus.value_out), 128'(32'h40));
    chk("b2b_cmp2", 128'(bus.comp_result_out), 128'(1));
    chk("b2b_op2",  128'(bus.op_out.op), 128'(UOP_BLT));
    step();

    // MULHU with a following ADD held by issue until ready
    bus.op_in = mk(UOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6'd5, 5'd4);
    step();
    chk("mul_ready0", 128'(bus.exec_ready), 128'(0));
    bus.op_in = mk(UOP_ADD, 1, 2, 0, 6'd6, 5'd5);
    step();
    chk("mul_bubble", 128'(bus.op_out.busy), 128'(0));
    chk("mul_ready1", 128'(bus.exec_ready), 128'(1));
    step();
    bus.op_in = '0;
    chk("mul_val", 128'(bus.value_out), 128'(32'hFFFF_FFFE));
    chk("mul_op",  128'(bus.op_out.op), 128'(UOP_MULHU));
    step();
    chk("held_add_val", 128'(bus.value_out), 128'(3));
    chk("held_add_op",  128'(bus.op_out.op), 128'(UOP_ADD));
    step();

    // assorted single-cycle and multiply vectors
    run_op("sub",   mk(UOP_SUB, 3, 5, 0, 6'd1, 5'd6), 1, 32'hFFFF_FFFE, 1'b0);
    run_op("sra",   mk(UOP_SRA, 32'h8000_0000, 32'h24, 0, 6'd2, 5'd7), 1, 32'hF800_0000, 1'b0);
    run_op("sltu",  mk(UOP_SLTU, 1, 32'hFFFF_FFFF, 0, 6'd2, 5'd8), 1, 32'd1, 1'b0);
    run_op("jalr",  mk(UOP_JALR, 32'h1001, 0, 32'h10, 6'd7, 5'd9), 1, 32'h1010, 1'b1);
    run_op("store", mk(UOP_STORE, 32'h100, 32'h55, 32'h20, 6'd0, 5'd10), 1, 32'h120, 1'b0);
    run_op("bgeu",  mk(UOP_BGEU, 1, 32'hFFFF_FFFF, 32'h80, 6'd0, 5'd11), 1, 32'h80, 1'b0);
    run_op("beq",   mk(UOP_BEQ, 5, 5, 32'h44, 6'd0, 5'd12), 1, 32'h44, 1'b1);
    run_op("mul",   mk(UOP_MUL, 32'hFFFF_FFFF, 3, 0, 6'd8, 5'd13), 2, 32'hFFFF_FFFD, 1'b0);
    run_op("mulh",  mk(UOP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6'd8, 5'd14), 2, 32'h0, 1'b0);
    run_op("mulhsu", mk(UOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6'd8, 5'd15), 2, 32'hFFFF_FFFF, 1'b0);

`ifdef QU_EXEC_DIV_EN
    run_op("div_n7_2",  mk(UOP_DIV,  32'hFFFF_FFF9, 2, 0, 6'd9, 5'd16), 33, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_n7_2",  mk(UOP_REM,  32'hFFFF_FFF9, 2, 0, 6'd9, 5'd17), 33, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_5_0",  mk(UOP_DIVU, 5, 0, 0, 6'd9, 5'd18), 33, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",   mk(UOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 6'd9, 5'd19), 33, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",   mk(UOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 6'd9, 5'd20), 33, 32'h0, 1'b0);
    run_op("remu_5_0",  mk(UOP_REMU, 5, 0, 0, 6'd9, 5'd21), 33, 32'h5, 1'b0);
    run_op("divu_100_7", mk(UOP_DIVU, 100, 7, 0, 6'd9, 5'd22), 33, 32'd14, 1'b0);

    // flush at cycle 10 of a divide
    bus.op_in = mk(UOP_DIV, 100, 7, 0, 6'd10, 5'd23);
    step();
    bus.op_in = '0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fdiv_ready", 128'(bus.exec_ready), 128'(1));
    chk("fdiv_busy",  128'(bus.op_out.busy), 128'(0));
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.op_out.busy) seen = 1'b1;
    end
    chk("fdiv_no_result", 128'(seen), 128'(0));

    // reset mid-divide
    bus.op_in = mk(UOP_DIV, 100, 7, 0, 6'd10, 5'd24);
    step();
    bus.op_in = '0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rdiv_ready", 128'(bus.exec_ready), 128'(1));
    chk("rdiv_op",    128'(bus.op_out), 128'(0));
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.op_out.busy) seen = 1'b1;
    end
    chk("rdiv_no_result", 128'(seen), 128'(0));
`else
    run_op("div_9_3",  mk(UOP_DIV,  9, 3, 0, 6'd9, 5'd16), 1, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_9_3", mk(UOP_REMU, 9, 3, 0, 6'd9, 5'd17), 1, 32'hFFFF_FFFF, 1'b0);
    chk("nodiv_ready", 128'(bus.exec_ready), 128'(1));
`endif

    // flush mid-multiply
    bus.op_in = mk(UOP_MUL, 6, 7, 0, 6'd11, 5'd25);
    step();
    bus.op_in = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fmul_ready", 128'(bus.exec_ready), 128'(1));
    chk("fmul_busy0", 128'(bus.op_out.busy), 128'(0));
    step();
    chk("fmul_busy1", 128'(bus.op_out.busy), 128'(0));

    // flush on an ALU accept cycle
    bus.op_in = mk(UOP_ADD, 20, 22, 0, 6'd12, 5'd26);
    flush = 1'b1;
    step();
    bus.op_in = '0;
    flush = 1'b0;
    step();
    chk("falu_busy", 128'(bus.op_out.busy), 128'(0));
    chk("falu_val",  128'(bus.value_out), 128'(0));
    run_op("post_flush_add", mk(UOP_ADD, 20, 22, 0, 6'd12, 5'd27), 1, 32'd42, 1'b0);

    // flush while idle
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fidle_ready", 128'(bus.exec_ready), 128'(1));

    // reset together with flush mid-multiply
    bus.op_in = mk(UOP_MUL, 6, 7, 0, 6'd13, 5'd28);
    step();
    bus.op_in = '0;
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    chk("rmul_ready", 128'(bus.exec_ready), 128'(1));
    chk("rmul_val",   128'(bus.value_out), 128'(0));
    chk("rmul_op",    128'(bus.op_out), 128'(0));
    step();
    chk("rmul_busy",  128'(bus.op_out.busy), 128'(0));
    run_op("post_rst_add", mk(UOP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 6'd14, 5'd29), 1, 32'h0FF0_0FF0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
